store_rmw_unit: RTL and testbench

- Memory-side write engine for sw/sh/sb in the multicycle MIPS datapath.
- Counterpart of the load-size path: the load path extracts bytes and halfwords from a memory word; this block inserts them.
- Control unit pulses start with address (ALUOut), store data (B) and size.
- Word stores write directly. Halfword and byte stores do a read-modify-write on the word-only memory.

---
 rtl/store_rmw_unit.sv | 163 ++++++++++++++++
 tb/tb_store_rmw_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_unit.sv
// Store engine for sw/sh/sb: word stores write directly, half/byte stores read-modify-write.
// Optional read-back verification of the written word is enabled by defining STORE_READBACK_EN.
module store_rmw_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic        verify_err
);

    typedef enum logic [2:0] {
        StIdle, StErr, StRead, StCapture, StWrite, StDone, StVread, StVcheck
    } state_e;

    // Read states last MEM_LATENCY cycles; the counter tracks the final one.
    localparam logic [1:0] LastCnt = 2'(MEM_LATENCY - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_wr_q, mem_wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mis_q, mis_d;
    logic        verr_q, verr_d;
    logic        illegal;

    function automatic logic [31:0] merge_word(input logic [31:0] base, input logic [31:0] data,
                                               input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] w;
        w = base;
        if (sz == 2'b01) begin
            if (off[1]) w[31:16] = data[15:0];
            else        w[15:0]  = data[15:0];
        end else begin
            w[{off, 3'b000} +: 8] = data[7:0];
        end
        return w;
    endfunction

    assign illegal = (size == 2'b11) ||
                     (size == 2'b00 && addr[1:0] != 2'b00) ||
                     (size == 2'b01 && addr[0]);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        mem_wdata_d = mem_wdata_q;
        verr_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = addr;
                    size_d  = size;
                    wdata_d = wdata;
                    cnt_d   = 2'd0;
                    if (illegal) begin
                        state_d = StErr;
                    end else if (size == 2'b00) begin
                        state_d     = StWrite;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StErr: state_d = StIdle;
            StRead: begin
                if (cnt_q == LastCnt) begin
                    state_d = StCapture;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StCapture: begin
                state_d     = StWrite;
                mem_wdata_d = merge_word(mem_rdata, wdata_q, size_q, addr_q[1:0]);
            end
`ifdef STORE_READBACK_EN
            StWrite: begin
                state_d = StVread;
                cnt_d   = 2'd0;
            end
            StVread: begin
                if (cnt_q == LastCnt) begin
                    state_d = StVcheck;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StVcheck: begin
                state_d = StDone;
                verr_d  = (mem_rdata != mem_wdata_q);
            end
`else
            StWrite: state_d = StDone;
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Outputs are registered, so they are decoded from the state being entered.
        mem_wr_d = (state_d == StWrite);
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone) || (state_d == StErr);
        mis_d    = (state_d == StErr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= 32'd0;
            size_q      <= 2'd0;
            wdata_q     <= 32'd0;
            cnt_q       <= 2'd0;
            mem_wdata_q <= 32'd0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            verr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_q    <= mem_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
            verr_q      <= verr_d;
        end
    end

    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wr     = mem_wr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign misaligned = mis_q;
    assign verify_err = verr_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Scoreboard bench for store_rmw_unit: two instances (MEM_LATENCY 1 and 3) with memory models.
// Expected writes and completions are queued by the stimulus and checked by a monitor.
module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s     [2];
    logic [1:0]  size_s      [2];
    logic [31:0] addr_s      [2];
    logic [31:0] wdata_s     [2];
    logic [31:0] rdata_s     [2];
    logic [31:0] mem_addr_s  [2];
    logic        mem_wr_s    [2];
    logic [31:0] mem_wdata_s [2];
    logic        busy_s      [2];
    logic        done_s      [2];
    logic        mis_s       [2];
    logic        verr_s      [2];

    logic [31:0] mem  [2][64];
    logic [31:0] pipe [2][3];
    logic        pl_en [2];
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;
    logic        corrupt;

    typedef struct { int d; logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int d; int cyc; logic mis; logic verr; } dn_t;
    wr_t wrq[$];
    dn_t dnq[$];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic prev_wr [2];
    logic prev_done [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    store_rmw_unit #(.MEM_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .start(start_s[0]), .size(size_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .mem_rdata(rdata_s[0]), .mem_addr(mem_addr_s[0]),
        .mem_wr(mem_wr_s[0]), .mem_wdata(mem_wdata_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .misaligned(mis_s[0]), .verify_err(verr_s[0])
    );

    store_rmw_unit #(.MEM_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(reset), .start(start_s[1]), .size(size_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .mem_rdata(rdata_s[1]), .mem_addr(mem_addr_s[1]),
        .mem_wr(mem_wr_s[1]), .mem_wdata(mem_wdata_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .misaligned(mis_s[1]), .verify_err(verr_s[1])
    );

    // Memory model: read data appears MEM_LATENCY cycles after the address is presented.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (pl_en[d]) mem[d][pl_idx] <= pl_val;
            else if (mem_wr_s[d])
                mem[d][mem_addr_s[d][7:2]] <= corrupt ? (mem_wdata_s[d] ^ 32'h1) : mem_wdata_s[d];
            pipe[d][0] <= mem[d][mem_addr_s[d][7:2]];
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end
    end
    assign rdata_s[0] = pipe[0][0];
    assign rdata_s[1] = pipe[1][2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int d);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: dut %0d event not expected (cycle %0d)", name, d, cyc);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_wr_s[d]) begin
                check("wr_not_consecutive", 32'(prev_wr[d]), 32'd0);
                if (wrq.size() == 0 || wrq[0].d != d) begin
                    flag("unexpected_write", d);
                end else begin
                    check("wr_addr", mem_addr_s[d], wrq[0].addr);
                    check("wr_data", mem_wdata_s[d], wrq[0].data);
                    void'(wrq.pop_front());
                end
            end
            if (done_s[d]) begin
                check("busy_at_done", 32'(busy_s[d]), 32'd1);
                if (dnq.size() == 0 || dnq[0].d != d) begin
                    flag("unexpected_done", d);
                end else begin
                    check("done_cycle", 32'(cyc), 32'(dnq[0].cyc));
                    check("misaligned", 32'(mis_s[d]), 32'(dnq[0].mis));
                    check("verify_err", 32'(verr_s[d]), 32'(dnq[0].verr));
                    void'(dnq.pop_front());
                end
            end else begin
                if (mis_s[d] || verr_s[d]) flag("error_without_done", d);
            end
            if (prev_done[d]) check("busy_after_done", 32'(busy_s[d]), 32'd0);
            prev_wr[d]   = mem_wr_s[d];
            prev_done[d] = done_s[d];
        end
    end

    function automatic int lat_word(input int l);
`ifdef STORE_READBACK_EN
        return 3 + l;
`else
        return 2 + 0 * l;
`endif
    endfunction

    function automatic int lat_hb(input int l);
`ifdef STORE_READBACK_EN
        return 4 + 2 * l;
`else
        return 3 + l;
`endif
    endfunction

    task automatic preload(input int d, input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        pl_en[d] = 1'b1;
        pl_idx   = a[7:2];
        pl_val   = v;
        @(negedge clk);
        pl_en[d] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && dnq.size() != 0; i++) @(negedge clk);
        if (dnq.size() != 0) begin
            check("completion_timeout", 32'(dnq.size()), 32'd0);
            dnq.delete();
            wrq.delete();
        end
    endtask

    task automatic run_op(input int d, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int lat, input logic mis,
                          input logic [31:0] wexp, input logic verr, input logic poke);
        wr_t w;
        dn_t e;
        @(negedge clk);
        if (!mis) begin
            w.d = d; w.addr = {a[31:2], 2'b00}; w.data = wexp;
            wrq.push_back(w);
        end
        e.d = d; e.cyc = cyc + lat; e.mis = mis; e.verr = verr;
        dnq.push_back(e);
        start_s[d] = 1'b1; size_s[d] = sz; addr_s[d] = a; wdata_s[d] = wd;
        @(negedge clk);
        // Scramble the inputs after capture; a poke also re-pulses start while busy.
        start_s[d] = poke; size_s[d] = 2'b00; addr_s[d] = 32'h80; wdata_s[d] = 32'hBAD0BAD0;
        if (poke) @(negedge clk);
        start_s[d] = 1'b0;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        corrupt = 1'b0;
        pl_idx  = '0;
        pl_val  = '0;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; size_s[d] = '0; addr_s[d] = '0; wdata_s[d] = '0;
            pl_en[d] = 1'b0; prev_wr[d] = 1'b0; prev_done[d] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_busy", 32'(busy_s[d]), 32'd0);
            check("rst_done", 32'(done_s[d]), 32'd0);
            check("rst_mem_wr", 32'(mem_wr_s[d]), 32'd0);
            check("rst_misaligned", 32'(mis_s[d]), 32'd0);
            check("rst_verify_err", 32'(verr_s[d]), 32'd0);
            check("rst_mem_addr", mem_addr_s[d], 32'd0);
            check("rst_mem_wdata", mem_wdata_s[d], 32'd0);
        end
        reset = 1'b0;

        // Word, byte and half stores on the latency-1 instance.
        run_op(0, 2'b00, 32'h10, 32'hDEADBEEF, lat_word(1), 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        preload(0, 32'h20, 32'h11223344);
        run_op(0, 2'b10, 32'h23, 32'h000000AB, lat_hb(1), 1'b0, 32'hAB223344, 1'b0, 1'b0);
        run_op(0, 2'b10, 32'h21, 32'hFFFFFFCD, lat_hb(1), 1'b0, 32'hAB22CD44, 1'b0, 1'b0);
        preload(0, 32'h40, 32'hFFFFFFFF);
        run_op(0, 2'b01, 32'h42, 32'h12345678, lat_hb(1), 1'b0, 32'h5678FFFF, 1'b0, 1'b0);
        run_op(0, 2'b01, 32'h40, 32'h12345678, lat_hb(1), 1'b0, 32'h56785678, 1'b0, 1'b0);

        // Alignment errors and the illegal size code.
        run_op(0, 2'b01, 32'h41, 32'h0, 1, 1'b1, 32'h0, 1'b0, 1'b0);
        run_op(0, 2'b00, 32'h06, 32'h0, 1, 1'b1, 32'h0, 1'b0, 1'b0);
        run_op(0, 2'b11, 32'h30, 32'h0, 1, 1'b1, 32'h0, 1'b0, 1'b0);

        // Reset during CAPTURE drops the store.
        preload(0, 32'h50, 32'h01020304);
        @(negedge clk);
        start_s[0] = 1'b1; size_s[0] = 2'b10; addr_s[0] = 32'h51; wdata_s[0] = 32'hEE;
        @(negedge clk);
        start_s[0] = 1'b0;
        check("rmw_read_addr", mem_addr_s[0], 32'h50);
        check("rmw_read_nowr", 32'(mem_wr_s[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_busy", 32'(busy_s[0]), 32'd0);
        repeat (5) @(negedge clk);
        check("reset_mid_mem", mem[0][20], 32'h01020304);
        run_op(0, 2'b00, 32'h54, 32'hCAFEF00D, lat_word(1), 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);

        // Latency-3 byte store with a start pulse while busy.
        preload(1, 32'h60, 32'h11111111);
        run_op(1, 2'b10, 32'h62, 32'h0000005A, lat_hb(3), 1'b0, 32'h115A1111, 1'b0, 1'b1);
        run_op(1, 2'b01, 32'h60, 32'h0000BEEF, lat_hb(3), 1'b0, 32'h115ABEEF, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("ignored_start_mem", mem[1][32], 32'h0);

`ifdef STORE_READBACK_EN
        // A corrupting memory must be caught on read-back.
        corrupt = 1'b1;
        run_op(0, 2'b00, 32'h70, 32'h0F0F0F0F, lat_word(1), 1'b0, 32'h0F0F0F0F, 1'b1, 1'b0);
        corrupt = 1'b0;
        run_op(1, 2'b10, 32'h70, 32'h0000003C, lat_hb(3), 1'b0, 32'h0000003C, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("pending_writes", 32'(wrq.size()), 32'd0);
        check("pending_dones", 32'(dnq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) mem[d][i] = 32'h0;
    end

endmodule
